// File: rtl/sad_pkg.sv
// Shared helpers and default-derived constants for the SAD processing element.
package sad_pkg;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   localparam int unsigned PIX_W_DEF    = 8;
   localparam int unsigned LANES_DEF    = 16;
   localparam int unsigned BEATS_DEF    = 16;
   localparam int unsigned NUM_CAND_DEF = 289;

   localparam int unsigned L     = clog2(LANES_DEF);
   localparam int unsigned SAD_W = PIX_W_DEF + clog2(LANES_DEF * BEATS_DEF);
   localparam int unsigned IDX_W = clog2(NUM_CAND_DEF);
   localparam int unsigned LAT   = L + 2;

   typedef enum logic {
      FRM_IDLE,
      FRM_OPEN
   } frm_state_t;

endpackage

// File: rtl/sad_pe_pipe_if.sv
// Beat input, search control and result bundle of the SAD processing element.
interface sad_pe_pipe_if #(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned LANES = 16,
   parameter int unsigned SAD_W = 16,
   parameter int unsigned IDX_W = 9
);
   logic                   enable;
   logic                   in_valid;
   logic                   in_first;
   logic                   in_last;
   logic [LANES*PIX_W-1:0] cur_pix;
   logic [LANES*PIX_W-1:0] ref_pix;
   logic                   search_start;
   logic [SAD_W-1:0]       sad;
   logic                   sad_valid;
   logic [IDX_W-1:0]       sad_idx;
   logic [SAD_W-1:0]       best_sad;
   logic [IDX_W-1:0]       best_idx;
   logic                   best_valid;
   logic                   err;

   modport master (
      output enable, in_valid, in_first, in_last, cur_pix, ref_pix, search_start,
      input  sad, sad_valid, sad_idx, best_sad, best_idx, best_valid, err
   );

   modport slave (
      input  enable, in_valid, in_first, in_last, cur_pix, ref_pix, search_start,
      output sad, sad_valid, sad_idx, best_sad, best_idx, best_valid, err
   );
endinterface

// File: rtl/sad_adder_tree.sv
// Registered pairwise adder tree, one level per cycle, with valid/first/last sideband.
module sad_adder_tree
   import sad_pkg::*;
#(
   parameter int unsigned LANES = 16,
   parameter int unsigned IN_W  = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             en,
   input  logic                             in_valid,
   input  logic                             in_first,
   input  logic                             in_last,
   input  logic [LANES*IN_W-1:0]            in_data,
   output logic                             out_valid,
   output logic                             out_first,
   output logic                             out_last,
   output logic [IN_W+clog2(LANES)-1:0]     out_sum
);
   localparam int unsigned TL = clog2(LANES);

   logic [TL-1:0] v_d, v_q, f_d, f_q, l_d, l_q;

   always_comb begin
      v_d    = v_q;
      f_d    = f_q;
      l_d    = l_q;
      v_d[0] = in_valid;
      f_d[0] = in_first;
      l_d[0] = in_last;
      for (int unsigned i = 1; i < TL; i++) begin
         v_d[i] = v_q[i-1];
         f_d[i] = f_q[i-1];
         l_d[i] = l_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         f_q <= '0;
         l_q <= '0;
      end else if (en) begin
         v_q <= v_d;
         f_q <= f_d;
         l_q <= l_d;
      end
   end

   for (genvar j = 0; j < TL; j++) begin : g_lvl
      localparam int unsigned N  = LANES >> (j + 1);
      localparam int unsigned IW = IN_W + j;

      logic [2*N*IW-1:0]   src;
      logic [N*(IW+1)-1:0] sum_d, sum_q;

      if (j == 0) begin : g_in
         assign src = in_data;
      end else begin : g_prev
         assign src = g_lvl[j-1].sum_q;
      end

      always_comb begin
         sum_d = '0;
         for (int unsigned k = 0; k < N; k++) begin
            sum_d[k*(IW+1) +: (IW+1)] = (IW+1)'(src[(2*k)*IW +: IW]) +
                                        (IW+1)'(src[(2*k+1)*IW +: IW]);
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)  sum_q <= '0;
         else if (en) sum_q <= sum_d;
      end
   end

   assign out_sum   = g_lvl[TL-1].sum_q;
   assign out_valid = v_q[TL-1];
   assign out_first = f_q[TL-1];
   assign out_last  = l_q[TL-1];

endmodule

// File: rtl/sad_pe_pipe.sv
// SAD processing element: abs-diff stage, adder tree, framed accumulator,
// registered result stage and per-window running-minimum tracker.
module sad_pe_pipe
   import sad_pkg::*;
#(
   parameter int unsigned PIX_W    = 8,
   parameter int unsigned LANES    = 16,
   parameter int unsigned BEATS    = 16,
   parameter int unsigned NUM_CAND = 289
) (
   input  logic          clk,
   input  logic          rst_n,
   sad_pe_pipe_if.slave  bus
);
   localparam int unsigned TL  = clog2(LANES);
   localparam int unsigned TW  = PIX_W + TL;
   localparam int unsigned SW  = PIX_W + clog2(LANES * BEATS);
   localparam int unsigned IW  = clog2(NUM_CAND);
   localparam int unsigned BCW = clog2(BEATS + 1);

   logic [LANES*PIX_W-1:0] ad_d, ad_q;
   logic                   s0_v_q, s0_f_q, s0_l_q;
   logic                   t_v, t_f, t_l;
   logic [TW-1:0]          t_sum;

   frm_state_t             state_d, state_q;
   logic [SW-1:0]          acc_d, acc_q;
   logic [SW:0]            acc_sum;
   logic [BCW-1:0]         bcnt_d, bcnt_q;
   logic                   done_d, done_q;
   logic                   err_d, err_q;

   logic [SW-1:0]          sad_d, sad_q;
   logic [IW-1:0]          idx_d, sad_idx_q, cand_d, cand_q;
   logic                   sad_vld_q;

   logic [SW-1:0]          nb, wb_d, wb_q, bs_d, best_sad_q;
   logic [IW-1:0]          ni, wi_d, wi_q, bi_d, best_idx_q;
   logic                   bv_d, best_vld_q;

   always_comb begin
      ad_d = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         ad_d[i*PIX_W +: PIX_W] =
            (bus.cur_pix[i*PIX_W +: PIX_W] >= bus.ref_pix[i*PIX_W +: PIX_W]) ?
            bus.cur_pix[i*PIX_W +: PIX_W] - bus.ref_pix[i*PIX_W +: PIX_W] :
            bus.ref_pix[i*PIX_W +: PIX_W] - bus.cur_pix[i*PIX_W +: PIX_W];
      end
   end

   sad_adder_tree #(
      .LANES (LANES),
      .IN_W  (PIX_W)
   ) u_tree (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (bus.enable),
      .in_valid  (s0_v_q),
      .in_first  (s0_f_q),
      .in_last   (s0_l_q),
      .in_data   (ad_q),
      .out_valid (t_v),
      .out_first (t_f),
      .out_last  (t_l),
      .out_sum   (t_sum)
   );

   // Framing state: a block is open between an accepted first beat and its last beat.
   always_comb begin
      state_d = state_q;
      if (t_v) begin
         if (t_f || state_q == FRM_OPEN) state_d = t_l ? FRM_IDLE : FRM_OPEN;
      end
   end

   always_comb begin
      acc_sum = {1'b0, acc_q} + (SW+1)'(t_sum);
      acc_d   = acc_q;
      bcnt_d  = bcnt_q;
      done_d  = 1'b0;
      err_d   = err_q;
      if (t_v) begin
         if (t_f) begin
            if (state_q == FRM_OPEN) err_d = 1'b1;
            acc_d  = SW'(t_sum);
            bcnt_d = BCW'(1);
            done_d = t_l;
         end else if (state_q == FRM_IDLE) begin
            err_d = 1'b1;
         end else begin
            acc_d = acc_sum[SW] ? '1 : acc_sum[SW-1:0];
            if (bcnt_q >= BCW'(BEATS)) err_d = 1'b1;
            else                       bcnt_d = bcnt_q + 1'b1;
            done_d = t_l;
         end
      end
   end

   // A search_start coincident with a completed block makes that block candidate 0.
   always_comb begin
      sad_d  = sad_q;
      idx_d  = sad_idx_q;
      cand_d = cand_q;
      if (done_q) begin
         sad_d  = acc_q;
         idx_d  = bus.search_start ? '0 : cand_q;
         cand_d = (idx_d == IW'(NUM_CAND - 1)) ? '0 : idx_d + 1'b1;
      end else if (bus.search_start) begin
         cand_d = '0;
      end
   end

   always_comb begin
      nb   = wb_q;
      ni   = wi_q;
      wb_d = wb_q;
      wi_d = wi_q;
      bs_d = best_sad_q;
      bi_d = best_idx_q;
      bv_d = 1'b0;
      if (sad_vld_q) begin
         if (sad_idx_q == '0 || sad_q < wb_q) begin
            nb = sad_q;
            ni = sad_idx_q;
         end
         wb_d = nb;
         wi_d = ni;
         if (sad_idx_q == IW'(NUM_CAND - 1)) begin
            bs_d = nb;
            bi_d = ni;
            bv_d = 1'b1;
         end
      end
      if (bus.search_start) begin
         wb_d = '0;
         wi_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FRM_IDLE;
      else if (bus.enable) state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ad_q       <= '0;
         s0_v_q     <= 1'b0;
         s0_f_q     <= 1'b0;
         s0_l_q     <= 1'b0;
         acc_q      <= '0;
         bcnt_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         sad_q      <= '0;
         sad_idx_q  <= '0;
         sad_vld_q  <= 1'b0;
         cand_q     <= '0;
         wb_q       <= '0;
         wi_q       <= '0;
         best_sad_q <= '0;
         best_idx_q <= '0;
         best_vld_q <= 1'b0;
      end else if (bus.enable) begin
         ad_q       <= ad_d;
         s0_v_q     <= bus.in_valid;
         s0_f_q     <= bus.in_first;
         s0_l_q     <= bus.in_last;
         acc_q      <= acc_d;
         bcnt_q     <= bcnt_d;
         done_q     <= done_d;
         err_q      <= err_d;
         sad_q      <= sad_d;
         sad_idx_q  <= idx_d;
         sad_vld_q  <= done_q;
         cand_q     <= cand_d;
         wb_q       <= wb_d;
         wi_q       <= wi_d;
         best_sad_q <= bs_d;
         best_idx_q <= bi_d;
         best_vld_q <= bv_d;
      end
   end

   assign bus.sad        = sad_q;
   assign bus.sad_valid  = sad_vld_q & bus.enable;
   assign bus.sad_idx    = sad_idx_q;
   assign bus.best_sad   = best_sad_q;
   assign bus.best_idx   = best_idx_q;
   assign bus.best_valid = best_vld_q & bus.enable;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_sad_pe_pipe.sv
// Randomized self-checking bench: two DUTs (default window and a 4-candidate
// window) share one stimulus stream and are compared against a block-level model.
module tb_sad_pe_pipe;
   import sad_pkg::*;

   localparam int unsigned NC_A = 289;
   localparam int unsigned NC_B = 4;
   localparam int unsigned SATV = 65535;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0, v = 1'b0, f = 1'b0, l = 1'b0, ss = 1'b0;
   logic [127:0] cur = '0, refp = '0;

   int n_vec = 0, n_bad = 0;
   int cyc = 0, ecyc = 0;
   int sad_pulses = 0, last_sad_cyc = 0, best_pulses = 0, last_b3_e = 0;

   int qa_sad[$], qa_idx[$], qa_t[$], qb_sad[$], qb_idx[$], qbest_sad[$], qbest_idx[$];
   bit m_open = 0, m_err = 0;
   int m_acc = 0, m_cnt = 0, cand_a = 0, cand_b = 0, wb = 0, wi = 0, last_exp = 0;

   sad_pe_pipe_if #(.PIX_W(8), .LANES(16), .SAD_W(16), .IDX_W(clog2(NC_A))) ifa ();
   sad_pe_pipe_if #(.PIX_W(8), .LANES(16), .SAD_W(16), .IDX_W(clog2(NC_B))) ifb ();

   assign ifa.enable = en;   assign ifb.enable = en;
   assign ifa.in_valid = v;  assign ifb.in_valid = v;
   assign ifa.in_first = f;  assign ifb.in_first = f;
   assign ifa.in_last = l;   assign ifb.in_last = l;
   assign ifa.cur_pix = cur; assign ifb.cur_pix = cur;
   assign ifa.ref_pix = refp; assign ifb.ref_pix = refp;
   assign ifa.search_start = ss; assign ifb.search_start = ss;

   sad_pe_pipe #(.PIX_W(8), .LANES(16), .BEATS(16), .NUM_CAND(NC_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   sad_pe_pipe #(.PIX_W(8), .LANES(16), .BEATS(16), .NUM_CAND(NC_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (en) ecyc <= ecyc + 1;
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      qa_sad.delete(); qa_idx.delete(); qa_t.delete();
      qb_sad.delete(); qb_idx.delete(); qbest_sad.delete(); qbest_idx.delete();
      m_open = 0; m_err = 0; m_acc = 0; m_cnt = 0; cand_a = 0; cand_b = 0;
   endtask

   task automatic emit(input int s);
      qa_sad.push_back(s); qa_idx.push_back(cand_a); qa_t.push_back(ecyc + LAT);
      cand_a = (cand_a + 1) % NC_A;
      qb_sad.push_back(s); qb_idx.push_back(cand_b);
      if (cand_b == 0 || s < wb) begin wb = s; wi = cand_b; end
      if (cand_b == NC_B - 1) begin qbest_sad.push_back(wb); qbest_idx.push_back(wi); end
      cand_b = (cand_b + 1) % NC_B;
      last_exp = s;
   endtask

   task automatic model_beat(input bit ff, input bit ll, input logic [127:0] c, input logic [127:0] r);
      int s;
      s = 0;
      for (int i = 0; i < 16; i++) begin
         int a, b;
         a = int'(c[8*i +: 8]);
         b = int'(r[8*i +: 8]);
         s += (a > b) ? a - b : b - a;
      end
      if (ff) begin
         if (m_open) m_err = 1;
         m_acc = s; m_cnt = 1; m_open = 1;
      end else if (!m_open) begin
         m_err = 1;
         return;
      end else begin
         m_cnt++;
         if (m_cnt > 16) m_err = 1;
         m_acc = (m_acc + s > SATV) ? SATV : m_acc + s;
      end
      if (ll) begin
         m_open = 0;
         emit(m_acc);
      end
   endtask

   task automatic step(input bit e, input bit vv, input bit ff, input bit ll,
                       input logic [127:0] c, input logic [127:0] r, input bit s);
      en = e; v = vv; f = ff; l = ll; cur = c; refp = r; ss = s;
      @(posedge clk); #1;
      if (e && vv) model_beat(ff, ll, c, r);
      if (e && s) begin cand_a = 0; cand_b = 0; end
      en = 1; v = 0; f = 0; l = 0; ss = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, '0, '0, 0);
   endtask

   task automatic drain();
      idle(LAT + 6);
      chk("drain_a", qa_sad.size(), 0);
      chk("drain_b", qb_sad.size(), 0);
      chk("drain_best", qbest_sad.size(), 0);
      chk("err_a", ifa.err, m_err);
      chk("err_b", ifb.err, m_err);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_sad"}, ifa.sad, 0);       chk({tag, "_sad_valid"}, ifa.sad_valid, 0);
      chk({tag, "_sad_idx"}, ifa.sad_idx, 0); chk({tag, "_best_sad"}, ifa.best_sad, 0);
      chk({tag, "_best_idx"}, ifa.best_idx, 0); chk({tag, "_best_valid"}, ifa.best_valid, 0);
      chk({tag, "_err"}, ifa.err, 0);       chk({tag, "_b_best_sad"}, ifb.best_sad, 0);
   endtask

   task automatic do_reset();
      rst_n = 0; #1;
      model_clear();
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (ifa.sad_valid) begin
            sad_pulses++;
            last_sad_cyc = cyc;
            if (qa_sad.size() == 0) chk("a_spurious_valid", ifa.sad_valid, 0);
            else begin
               chk("a_sad", ifa.sad, qa_sad.pop_front());
               chk("a_idx", ifa.sad_idx, qa_idx.pop_front());
               chk("a_latency", ecyc, qa_t.pop_front());
            end
         end
         if (ifb.sad_valid) begin
            if (qb_sad.size() == 0) chk("b_spurious_valid", ifb.sad_valid, 0);
            else begin
               int ei;
               ei = qb_idx.pop_front();
               chk("b_sad", ifb.sad, qb_sad.pop_front());
               chk("b_idx", ifb.sad_idx, ei);
               if (ei == NC_B - 1) last_b3_e = ecyc;
            end
         end
         if (ifb.best_valid) begin
            best_pulses++;
            if (qbest_sad.size() == 0) chk("b_spurious_best", ifb.best_valid, 0);
            else begin
               chk("b_best_sad", ifb.best_sad, qbest_sad.pop_front());
               chk("b_best_idx", ifb.best_idx, qbest_idx.pop_front());
               chk("b_best_latency", ecyc, last_b3_e + 1);
            end
         end
      end
   end

   initial begin
      int c0, p0, b0;
      logic [127:0] c, r;

      #1 check_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      idle(2);

      // 1: single beat, full-scale difference
      step(1, 1, 1, 1, '1, '0, 0);
      drain();
      chk("t1_sad", ifa.sad, 4080);
      chk("t1_idx", ifa.sad_idx, 0);

      // 2: mirrored ramps, both operand orders
      for (int i = 0; i < 16; i++) begin
         c[8*i +: 8] = 8'(i);
         r[8*i +: 8] = 8'(15 - i);
      end
      step(1, 1, 1, 1, c, r, 0);
      drain();
      chk("t2_sad", ifa.sad, 128);
      step(1, 1, 1, 1, r, c, 0);
      drain();
      chk("t2_sad_rev", ifa.sad, 128);

      // 3: 16 beats of diff 1 with a 3-cycle stall after beat 7
      p0 = sad_pulses;
      for (int k = 0; k < 16; k++) begin
         r = rnd128();
         for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = r[8*i +: 8] & 8'h7F;
            c[8*i +: 8] = r[8*i +: 8] + 8'd1;
         end
         if (k == 7) for (int s = 0; s < 3; s++) step(0, 1, 0, 0, c, r, 0);
         step(1, 1, k == 0, k == 15, c, r, 0);
         if (k == 0) c0 = cyc;
      end
      drain();
      chk("t3_sad", ifa.sad, 256);
      chk("t3_pulses", sad_pulses - p0, 1);
      chk("t3_wall_latency", last_sad_cyc - c0, 15 + 3 + LAT);

      // 4: new window on the 4-candidate DUT, SADs 50,30,30,40
      b0 = best_pulses;
      step(1, 0, 0, 0, '0, '0, 1);
      step(1, 1, 1, 1, 128'd50, '0, 0);
      step(1, 1, 1, 1, 128'd30, '0, 0);
      step(1, 1, 1, 1, '0, 128'd30, 0);
      step(1, 1, 1, 1, 128'd40, '0, 0);
      drain();
      chk("t4_best_sad", ifb.best_sad, 30);
      chk("t4_best_idx", ifb.best_idx, 1);
      chk("t4_best_pulses", best_pulses - b0, 1);

      // random blocks with stalls, bubbles and framing faults
      for (int blk = 0; blk < 40; blk++) begin
         int mode, len;
         bit e;
         mode = $urandom_range(0, 9);
         len = $urandom_range(1, 5);
         for (int k = 0; k < len; k++) begin
            c = rnd128();
            r = rnd128();
            do begin
               e = ($urandom_range(0, 3) != 0);
               step(e, 1, (k == 0) && (mode != 0), (k == len - 1) && (mode != 1), c, r, 0);
            end while (!e);
            if ($urandom_range(0, 4) == 0) idle(1);
         end
         if (blk == 20) begin
            drain();
            step(1, 0, 0, 0, '0, '0, 1);
         end
      end
      drain();

      // 5: reset in the middle of a 16-beat block, then stray beats, then a clean block
      for (int k = 0; k < 4; k++) step(1, 1, k == 0, 0, rnd128(), rnd128(), 0);
      en = 1; v = 1; f = 0; l = 0; cur = rnd128(); refp = rnd128();
      #2 rst_n = 0;
      #1 check_zero("t5_async");
      model_clear();
      v = 0;
      @(posedge clk); #1;
      rst_n = 1;
      p0 = sad_pulses;
      for (int k = 0; k < 3; k++) step(1, 1, 0, k == 2, rnd128(), rnd128(), 0);
      drain();
      chk("t5_stray_pulses", sad_pulses - p0, 0);
      chk("t5_err", ifa.err, 1);
      step(1, 1, 1, 0, rnd128(), rnd128(), 0);
      step(1, 1, 0, 1, rnd128(), rnd128(), 0);
      drain();
      chk("t5_clean_sad", ifa.sad, last_exp);
      chk("t5_clean_idx", ifa.sad_idx, 0);

      // 6: over-length saturating block, then first mid-block, then a clean 2-beat block
      do_reset();
      for (int k = 0; k < 17; k++) step(1, 1, k == 0, k == 16, '1, '0, 0);
      drain();
      chk("t6_sat_sad", ifa.sad, SATV);
      chk("t6_err", ifa.err, 1);
      for (int k = 0; k < 3; k++) step(1, 1, k == 0, 0, '1, '0, 0);
      for (int k = 0; k < 2; k++) begin
         r = rnd128();
         for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = r[8*i +: 8] | 8'h01;
            c[8*i +: 8] = r[8*i +: 8] - 8'd1;
         end
         step(1, 1, k == 0, k == 1, c, r, 0);
      end
      drain();
      chk("t6_restart_sad", ifa.sad, 32);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
